repsub_divider: RTL and testbench

//   Unsigned integer divider using repeated subtraction: a controller FSM plus

---
 rtl/repsub_divider.sv | 125 ++++++++++++
 tb/tb_repsub_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/repsub_divider.sv
// Unsigned repeated-subtraction divider: controller FSM plus A/B/Q/R datapath.
// Latency: done rises q+2 edges after the accepting edge (counting that edge); divide-by-zero and dividend<divisor take 2.
// Handshake: start is sampled only in IDLE, with no queueing; busy flags CHECK/SUB and done pulses once per operation.
module repsub_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SUB   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] b_reg;    // captured divisor
   logic [WIDTH-1:0] r_reg;    // running remainder, starts as the dividend
   logic [WIDTH-1:0] q_reg;    // running quotient

   // Datapath: one subtractor, one incrementer and two magnitude comparators.
   // diff_ge_b looks one subtraction ahead, so SUB leaves on the same edge
   // that performs the final subtraction instead of spending an extra cycle
   // rediscovering R<B.
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] q_inc;
   logic             b_is_zero;
   logic             r_ge_b;
   logic             diff_ge_b;

   assign diff      = r_reg - b_reg;
   assign q_inc     = q_reg + ONE;
   assign b_is_zero = (b_reg == '0);
   assign r_ge_b    = (r_reg >= b_reg);
   assign diff_ge_b = (diff >= b_reg);

   // Controller and all registered outputs; reset aborts any running operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         b_reg       <= '0;
         r_reg       <= '0;
         q_reg       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  b_reg       <= divisor;
                  r_reg       <= dividend;
                  q_reg       <= '0;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= CHECK;
               end
            end

            CHECK: begin
               if (b_is_zero) begin
                  // Saturated quotient and untouched dividend as remainder.
                  q_reg       <= '1;
                  quotient    <= '1;
                  remainder   <= r_reg;
                  div_by_zero <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end else if (!r_ge_b) begin
                  // Dividend smaller than divisor: nothing to subtract.
                  quotient    <= q_reg;
                  remainder   <= r_reg;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  state       <= SUB;
               end
            end

            SUB: begin
               // R>=B always holds on entry to SUB, so every SUB edge
               // subtracts; R never underflows and Q never passes the dividend.
               r_reg <= diff;
               q_reg <= q_inc;
               if (!diff_ge_b) begin
                  quotient  <= q_inc;
                  remainder <= diff;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_repsub_divider.sv
// Self-checking bench for repsub_divider with a queue-based scoreboard.
// Results, latency and busy length are checked on every done pulse.
// Also covers handshake corner cases and an asynchronous reset taken mid-operation.
module tb_repsub_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   repsub_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk    = 0;
   int   n_pass   = 0;
   int   edge_cnt = 0;
   int   busy_cnt = 0;
   logic done_prev = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Monitor: samples 1 time unit after each edge and scores every done pulse.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst) begin
         busy_cnt  = 0;
         done_prev = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            chk("done_width", done_prev, 0);
            chk("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", div_by_zero, e.dbz);
               chk("latency", edge_cnt - e.acc + 1, e.lat);
               chk("busy_cycles", busy_cnt, e.lat - 1);
            end
            busy_cnt = 0;
         end
         done_prev = done;
      end
   end

   // Wait for IDLE, present operands, and push the model result once accepted.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      exp_t e;
      int   t = 0;
      @(negedge clk);
      while ((busy || done) && t < 70000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 70000) begin
         chk("idle_wait", t, 0);
         return;
      end
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      e.dbz = (b == 0);
      e.q   = (b == 0) ? '1 : W'(a / b);
      e.r   = (b == 0) ? a  : W'(a % b);
      e.lat = (b == 0) ? 2  : int'(e.q) + 2;
      e.acc = edge_cnt;
      sb.push_back(e);
      if (!hold) start = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() > 0 && t < 70000) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic, small, equal, zero dividend, divide-by-zero and flag clearing.
      issue(16'd100, 16'd7, 0);   drain();
      issue(16'd5, 16'd9, 0);
      issue(16'd9, 16'd9, 0);
      issue(16'd0, 16'd3, 0);
      issue(16'd1234, 16'd0, 0);
      issue(16'd8, 16'd2, 0);     drain();

      // Worst case: quotient reaches all-ones without wrapping.
      issue(16'hFFFF, 16'd1, 0);  drain();

      // Start with new operands during SUB is ignored; operands change too.
      issue(16'd100, 16'd7, 0);
      repeat (5) @(negedge clk);
      dividend = 16'd50;
      divisor  = 16'd5;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'd3;
      divisor  = 16'd0;
      drain();

      // Start held high: back-to-back operations.
      issue(16'd30, 16'd4, 1);
      issue(16'd17, 16'd17, 1);
      issue(16'd7, 16'd0, 1);
      issue(16'd1000, 16'd33, 1);
      start = 1'b0;
      drain();

      // A few random operands.
      for (int i = 0; i < 6; i++) begin
         issue(W'($urandom_range(0, 2000)), W'($urandom_range(0, 40)), 0);
      end
      drain();

      // Asynchronous reset during SUB of 200/3 (previous result is nonzero).
      issue(16'd200, 16'd3, 0);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_dbz", div_by_zero, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_done", done, 0);
      issue(16'd200, 16'd3, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
